upp_rx_solver: RTL and testbench

- Receive-direction counterpart of the uPP transmit solver. The DSP pushes a frame of 16-bit words over uPP into the FPGA; this block writes them into a single-clock write FIFO.
- Frame handshake over GPIO: FPGA drives oGPIO5 = ready-to-receive; DSP drives iGPIO0 = frame sent.
- Applies WAIT back-pressure from FIFO fill, checks frame length, reports overflow/length errors.
- Sits between the uPP pins and the receive FIFO feeding the BLVDS transmit path.

---
 rtl/upp_rx_solver_pkg.sv | 21 ++
 rtl/upp_rx_solver_sync2.sv | 25 ++
 rtl/upp_rx_solver.sv | 202 ++++++++++++++++++++
 tb/tb_upp_rx_solver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upp_rx_solver_pkg.sv
// Shared definitions for the uPP receive solver and its transmit-side sibling.
package upp_rx_solver_pkg;

   localparam int UPP_DW  = 16;
   localparam int USEDW_W = 9;

   // Defaults shared with the transmit solver so both ends agree on framing.
   localparam int                 DEF_PACKET_WORDS = 256;
   localparam logic [USEDW_W-1:0] DEF_AFULL_LEVEL  = 9'd384;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ARM     = 3'd2,
      ST_RECEIVE = 3'd3,
      ST_CHECK   = 3'd4,
      ST_RELEASE = 3'd5,
      ST_GAP     = 3'd6
   } state_e;

endpackage

// File: rtl/upp_rx_solver_sync2.sv
// Two-flop synchronizer for a slow asynchronous DSP GPIO line.
module upp_rx_solver_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first one a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/upp_rx_solver.sv
// uPP receive solver: moves one DSP frame from the uPP pins into the write FIFO,
// runs the GPIO frame handshake, applies WAIT back-pressure and flags errors.
module upp_rx_solver
   import upp_rx_solver_pkg::*;
#(
   parameter int                 PACKET_WORDS   = DEF_PACKET_WORDS,
   parameter int                 FRAME_PACKETS  = 16,
   parameter logic [USEDW_W-1:0] AFULL_LEVEL    = DEF_AFULL_LEVEL,
   parameter logic [8:0]         BETWEEN_FRAMES = 9'd100,
   parameter logic [15:0]        RX_TIMEOUT     = 16'd50000
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iSTART,
   input  logic              iGPIO0,
   input  logic [UPP_DW-1:0] iUPP_DATA,
   input  logic              iUPP_ENA,
   input  logic [USEDW_W-1:0] iWR_USEDW,
   input  logic              iWR_FULL,
   output logic [UPP_DW-1:0] oWR_DATA,
   output logic              oWR_REQ,
   output logic              oACLR_FIFO,
   output logic              oGPIO5,
   output logic              oUPP_WAIT,
   output logic              oFRAME_DONE,
   output logic              oERR_OVF,
   output logic              oERR_LEN
);

   localparam logic [15:0] EXP = 16'(PACKET_WORDS * FRAME_PACKETS);

   logic              gpio0_s;

   state_e            state_q, state_d;
   logic              start_q, start_d;
   logic [UPP_DW-1:0] d1_q, d1_d;
   logic              ena1_q, ena1_d;
   logic [UPP_DW-1:0] wr_data_q, wr_data_d;
   logic              wr_req_q, wr_req_d;
   logic              aclr_q, aclr_d;
   logic              gpio5_q, gpio5_d;
   logic              upp_wait_q, upp_wait_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic              len_q, len_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [15:0]       tmo_cnt_q, tmo_cnt_d;
   logic [8:0]        gap_cnt_q, gap_cnt_d;

   upp_rx_solver_sync2 u_gpio0_sync (
      .clk   (iCLK),
      .rst_n (iRST_N),
      .d     (iGPIO0),
      .q     (gpio0_s)
   );

   // Frame sequencing, write path, error tracking and back-pressure.
   always_comb begin
      state_d    = state_q;
      start_d    = start_q | iSTART;
      d1_d       = iUPP_DATA;
      ena1_d     = iUPP_ENA;
      wr_data_d  = wr_data_q;
      wr_req_d   = 1'b0;
      aclr_d     = 1'b0;
      gpio5_d    = gpio5_q;
      upp_wait_d = 1'b0;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      gap_cnt_d  = gap_cnt_q;

      case (state_q)
         ST_IDLE: begin
            gpio5_d = 1'b0;
            if (start_q && !gpio0_s) begin
               state_d = ST_CLEAR;
               start_d = 1'b0;
               aclr_d  = 1'b1;
            end
         end

         ST_CLEAR: begin
            ovf_d      = 1'b0;
            len_d      = 1'b0;
            word_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = ST_ARM;
         end

         ST_ARM: begin
            gpio5_d = 1'b1;
            state_d = ST_RECEIVE;
         end

         ST_RECEIVE: begin
            gpio5_d    = 1'b1;
            upp_wait_d = (iWR_USEDW >= AFULL_LEVEL);
            if (ena1_q) begin
               tmo_cnt_d = '0;
               if (iWR_FULL) begin
                  ovf_d = 1'b1;
               end
               if (word_cnt_q >= EXP) begin
                  len_d = 1'b1;
               end
               if (!iWR_FULL && (word_cnt_q < EXP)) begin
                  wr_req_d   = 1'b1;
                  wr_data_d  = d1_q;
                  word_cnt_d = word_cnt_q + 16'd1;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
            if (gpio0_s) begin
               state_d = ST_CHECK;
            end else if (tmo_cnt_q == RX_TIMEOUT) begin
               len_d   = 1'b1;
               state_d = ST_CHECK;
            end
         end

         ST_CHECK: begin
            gpio5_d = 1'b0;
            done_d  = 1'b1;
            if (word_cnt_q != EXP) begin
               len_d = 1'b1;
            end
            state_d = ST_RELEASE;
         end

         ST_RELEASE: begin
            if (!gpio0_s) begin
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end
         end

         ST_GAP: begin
            if (({1'b0, gap_cnt_q} + 10'd1) >= {1'b0, BETWEEN_FRAMES}) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 9'd1;
            end
         end

         default: begin
            gpio5_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset forces every output quiet.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         d1_q       <= '0;
         ena1_q     <= 1'b0;
         wr_data_q  <= '0;
         wr_req_q   <= 1'b0;
         aclr_q     <= 1'b0;
         gpio5_q    <= 1'b0;
         upp_wait_q <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         len_q      <= 1'b0;
         word_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         d1_q       <= d1_d;
         ena1_q     <= ena1_d;
         wr_data_q  <= wr_data_d;
         wr_req_q   <= wr_req_d;
         aclr_q     <= aclr_d;
         gpio5_q    <= gpio5_d;
         upp_wait_q <= upp_wait_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign oWR_DATA    = wr_data_q;
   assign oWR_REQ     = wr_req_q;
   assign oACLR_FIFO  = aclr_q;
   assign oGPIO5      = gpio5_q;
   assign oUPP_WAIT   = upp_wait_q;
   assign oFRAME_DONE = done_q;
   assign oERR_OVF    = ovf_q;
   assign oERR_LEN    = len_q;

endmodule

// File: tb/tb_upp_rx_solver.sv
// Bench for the uPP receive solver: small frames (EXP = 8), short timeout and gap.
module tb_upp_rx_solver;

   localparam int EXP = 8;
   localparam int BF  = 10;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        iSTART = 1'b0;
   logic        iGPIO0 = 1'b0;
   logic [15:0] iUPP_DATA = '0;
   logic        iUPP_ENA = 1'b0;
   logic [8:0]  iWR_USEDW = '0;
   logic        iWR_FULL = 1'b0;
   logic [15:0] oWR_DATA;
   logic        oWR_REQ, oACLR_FIFO, oGPIO5, oUPP_WAIT, oFRAME_DONE, oERR_OVF, oERR_LEN;

   upp_rx_solver #(
      .PACKET_WORDS   (4),
      .FRAME_PACKETS  (2),
      .AFULL_LEVEL    (9'd384),
      .BETWEEN_FRAMES (9'd10),
      .RX_TIMEOUT     (16'd20)
   ) dut (
      .iCLK        (iCLK),
      .iRST_N      (iRST_N),
      .iSTART      (iSTART),
      .iGPIO0      (iGPIO0),
      .iUPP_DATA   (iUPP_DATA),
      .iUPP_ENA    (iUPP_ENA),
      .iWR_USEDW   (iWR_USEDW),
      .iWR_FULL    (iWR_FULL),
      .oWR_DATA    (oWR_DATA),
      .oWR_REQ     (oWR_REQ),
      .oACLR_FIFO  (oACLR_FIFO),
      .oGPIO5      (oGPIO5),
      .oUPP_WAIT   (oUPP_WAIT),
      .oFRAME_DONE (oFRAME_DONE),
      .oERR_OVF    (oERR_OVF),
      .oERR_LEN    (oERR_LEN)
   );

   always #5 iCLK = ~iCLK;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge iCLK) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      int          c;
   } wr_t;

   typedef struct {
      int nwords;
      int full_idx;
      bit timeout;
      int exp_nw;
      bit exp_len;
      bit exp_ovf;
   } vec_t;

   wr_t  got_q[$];
   wr_t  exp_q[$];
   int   fd_cnt = 0;
   int   aclr_cnt = 0;
   bit   pend_full = 1'b0;
   bit   mdl_len, mdl_ovf;
   vec_t vecs[6];

   // Monitor: records every FIFO write with its cycle, and counts pulses.
   always @(negedge iCLK) begin
      if (oWR_REQ) got_q.push_back('{oWR_DATA, cyc});
      if (oFRAME_DONE) fd_cnt++;
      if (oACLR_FIFO) aclr_cnt++;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=expired required=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   // One uPP bus cycle; FULL is presented one cycle later to line up with the
   // registered ena inside the block.
   task automatic applyStimulus(input bit ena, input logic [15:0] data, input bit full);
      iUPP_ENA  = ena;
      iUPP_DATA = data;
      iWR_FULL  = pend_full;
      pend_full = full;
      tick();
   endtask

   task automatic startFrame();
      int k;
      got_q.delete();
      fd_cnt   = 0;
      aclr_cnt = 0;
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      k = 0;
      while (!oGPIO5 && k < 50) begin
         tick();
         k++;
      end
      checkOutput("arm_wait", 32'(k < 50), 1);
      checkOutput("err_cleared", {oERR_OVF, oERR_LEN}, 0);
   endtask

   // Drives a frame and builds the reference: a word is kept while fewer than
   // EXP have been kept and FIFO is not full; any word past EXP is a length error.
   task automatic sendWords(input int n, input int full_idx, input bit rnd);
      int          acc;
      logic [15:0] w;
      bit          f;
      acc = 0;
      exp_q.delete();
      mdl_len   = 1'b0;
      mdl_ovf   = 1'b0;
      pend_full = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (rnd) begin
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 16'h0, 1'b0);
            w = 16'($urandom);
            f = ($urandom_range(0, 5) == 0);
         end else begin
            w = 16'(i + 1);
            f = (i == full_idx);
         end
         if (f) mdl_ovf = 1'b1;
         if (acc >= EXP) mdl_len = 1'b1;
         else if (!f) begin
            exp_q.push_back('{w, cyc + 2});
            acc++;
         end
         applyStimulus(1'b1, w, f);
      end
      applyStimulus(1'b0, 16'h0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0);
      if (acc != EXP) mdl_len = 1'b1;
   endtask

   task automatic endFrame(input bit timeout, input int exp_nw, input bit exp_len, input bit exp_ovf);
      int k;
      int n;
      k = 0;
      if (!timeout) iGPIO0 = 1'b1;
      while (!oFRAME_DONE && k < 200) begin
         tick();
         k++;
      end
      checkOutput("frame_done_seen", 32'(k < 200), 1);
      checkOutput("gpio5_low_at_done", oGPIO5, 0);
      checkOutput("err_len", oERR_LEN, exp_len);
      checkOutput("err_ovf", oERR_OVF, exp_ovf);
      repeat (3) tick();
      iGPIO0 = 1'b0;
      repeat (BF + 8) tick();
      checkOutput("ovf_sticky", oERR_OVF, exp_ovf);
      checkOutput("write_count", got_q.size(), exp_nw);
      checkOutput("done_pulses", fd_cnt, 1);
      checkOutput("aclr_pulses", aclr_cnt, 1);
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checkOutput("wr_data", got_q[i].data, exp_q[i].data);
         checkOutput("wr_latency", got_q[i].c, exp_q[i].c);
      end
   endtask

   task automatic runVec(input vec_t v);
      startFrame();
      sendWords(v.nwords, v.full_idx, 1'b0);
      endFrame(v.timeout, v.exp_nw, v.exp_len, v.exp_ovf);
   endtask

   initial begin
      int k;
      vecs[0] = '{8,  -1, 1'b0, 8, 1'b0, 1'b0};
      vecs[1] = '{6,  -1, 1'b0, 6, 1'b1, 1'b0};
      vecs[2] = '{10, -1, 1'b0, 8, 1'b1, 1'b0};
      vecs[3] = '{9,   3, 1'b0, 8, 1'b0, 1'b1};
      vecs[4] = '{3,  -1, 1'b1, 3, 1'b1, 1'b0};
      vecs[5] = '{0,  -1, 1'b0, 0, 1'b1, 1'b0};

      // Reset state.
      repeat (3) tick();
      checkOutput("reset_outputs",
                  {oWR_DATA, oWR_REQ, oACLR_FIFO, oGPIO5, oUPP_WAIT, oFRAME_DONE, oERR_OVF, oERR_LEN}, 0);
      iRST_N = 1'b1;
      tick();

      // Directed frames.
      foreach (vecs[i]) runVec(vecs[i]);

      // WAIT follows FIFO fill with one cycle lag, only while receiving.
      startFrame();
      iWR_USEDW = 9'd384;
      tick();
      checkOutput("wait_at_384", oUPP_WAIT, 1);
      iWR_USEDW = 9'd383;
      tick();
      checkOutput("wait_at_383", oUPP_WAIT, 0);
      iWR_USEDW = 9'd0;
      sendWords(8, -1, 1'b0);
      endFrame(1'b0, 8, 1'b0, 1'b0);
      iWR_USEDW = 9'd400;
      tick();
      tick();
      checkOutput("wait_idle", oUPP_WAIT, 0);
      iWR_USEDW = 9'd0;

      // Held GPIO0 keeps the block in RELEASE; the gap runs once it drops.
      startFrame();
      sendWords(8, -1, 1'b0);
      iGPIO0 = 1'b1;
      k = 0;
      while (!oFRAME_DONE && k < 200) begin
         tick();
         k++;
      end
      checkOutput("release_done_seen", 32'(k < 200), 1);
      iSTART = 1'b1;
      repeat (30) tick();
      checkOutput("release_holds", aclr_cnt, 1);
      iGPIO0 = 1'b0;
      k = 0;
      while (k < 100) begin
         tick();
         k++;
         if (oACLR_FIFO) break;
      end
      iSTART = 1'b0;
      checkOutput("gap_length", k, BF + 4);
      k = 0;
      while (!oGPIO5 && k < 50) begin
         tick();
         k++;
      end
      checkOutput("rearm_seen", 32'(k < 50), 1);
      // This frame's clear pulse was already observed above.
      got_q.delete();
      fd_cnt   = 0;
      aclr_cnt = 1;
      sendWords(0, -1, 1'b0);
      endFrame(1'b0, 0, 1'b1, 1'b0);

      // Reset in the middle of RECEIVE, then a clean frame.
      startFrame();
      pend_full = 1'b0;
      applyStimulus(1'b1, 16'h0011, 1'b0);
      applyStimulus(1'b1, 16'h0012, 1'b0);
      applyStimulus(1'b1, 16'h0013, 1'b0);
      #2;
      iRST_N = 1'b0;
      #1;
      checkOutput("midframe_reset_outputs",
                  {oWR_DATA, oWR_REQ, oACLR_FIFO, oGPIO5, oUPP_WAIT, oFRAME_DONE, oERR_OVF, oERR_LEN}, 0);
      iUPP_ENA = 1'b0;
      tick();
      iRST_N = 1'b1;
      tick();
      runVec(vecs[0]);

      // Random frames against the reference.
      for (int r = 0; r < 8; r++) begin
         startFrame();
         sendWords($urandom_range(0, 11), -1, 1'b1);
         endFrame(1'b0, exp_q.size(), mdl_len, mdl_ovf);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
